alu_seq_divider: RTL and testbench

- Multi-cycle unsigned divider that performs the inverse of the datapath's 8x8->16 multiply: a 16-bit dividend divided by an 8-bit divisor gives a 16-bit quotient and an 8-bit remainder.
- Sits beside the combinational ALU in the execute stage; the control unit issues a start pulse and stalls the pipeline while busy is high.
- Restoring algorithm, one quotient bit per clock.

---
 rtl/alu_seq_divider.sv | 145 ++++++++++++++
 tb/tb_alu_seq_divider.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_divider.sv
// ---------------------------------------------------------------------------
// alu_seq_divider
//
// Multi-cycle unsigned restoring divider. It sits beside the combinational
// ALU in the execute stage and does the inverse of the 8x8->16 multiply.
// A DIVIDEND_W-bit dividend divided by a DIVISOR_W-bit divisor gives a
// DIVIDEND_W-bit quotient and a DIVISOR_W-bit remainder. The divider
// produces one quotient bit per clock, MSB first. The control unit issues
// a start pulse and stalls the pipeline while busy is high.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled on the rising edge while IDLE or DONE
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while an iteration is in progress
//   done         one-cycle pulse; results are valid from this cycle onward
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend LSBs on divide by zero)
//   zero_flag    registered, 1 when quotient == 0
//   div_by_zero  registered, 1 when the last accepted divisor was 0
// ---------------------------------------------------------------------------
module alu_seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  zero_flag,
    output logic                  div_by_zero
);

    localparam int               CNT_W     = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [DIVISOR_W-1:0]    dsr;
    logic [DIVISOR_W-1:0]    pr;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    // After DIVIDEND_W shifts the register holds the whole quotient. It is
    // internal only; the quotient output is loaded just once, at completion.
    logic [DIVIDEND_W-1:0]   dq_sh;

    logic [DIVISOR_W:0]      trial;
    logic [DIVISOR_W-1:0]    trial_sub;
    logic                    q_bit;
    logic [DIVISOR_W-1:0]    pr_next;
    logic [DIVIDEND_W-1:0]   q_final;

    // One restoring step. The trial value is one bit wider than the divisor,
    // so the compare never overflows. When the subtraction is taken the true
    // difference is below the divisor. That difference fits in DIVISOR_W
    // bits, so a subtract that drops the top trial bit is exact. The stored
    // partial remainder therefore needs only DIVISOR_W bits.
    always_comb begin
        trial     = {pr, dq_sh[DIVIDEND_W-1]};
        q_bit     = (trial >= {1'b0, dsr});
        trial_sub = trial[DIVISOR_W-1:0] - dsr;
        pr_next   = q_bit ? trial_sub : trial[DIVISOR_W-1:0];
        q_final   = {dq_sh[DIVIDEND_W-2:0], q_bit};
    end

    // Control FSM and datapath registers. Outputs are registered and change
    // only at completion or on reset. A reset during RUN simply drops the
    // operation, so no done pulse is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            dsr         <= '0;
            pr          <= '0;
            dq_sh       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            zero_flag   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dq_sh <= dividend;
                        dsr   <= divisor;
                        pr    <= '0;
                        count <= '0;
                        if (divisor != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            // Divide by zero skips RUN and completes at once.
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            zero_flag   <= 1'b0;
                            div_by_zero <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    pr    <= pr_next;
                    dq_sh <= q_final;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_final;
                        remainder   <= pr_next;
                        zero_flag   <= (q_final == '0);
                        div_by_zero <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_divider
//
// Self-checking bench for alu_seq_divider. Each issued division pushes its
// expected result, computed with the / and % operators, onto a scoreboard
// queue. The result is popped and compared when done is observed. Each
// scenario task checks latency, busy duration, pulse width and output holding
// inline.
// ---------------------------------------------------------------------------
module tb_alu_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        zero_flag;
    logic        div_by_zero;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_seq_divider #(
        .DIVIDEND_W(16),
        .DIVISOR_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .zero_flag  (zero_flag),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, kept separate from the RTL algorithm.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t        e;
        logic [15:0] bw;
        logic [15:0] rem;
        bw = {8'd0, b};
        if (b == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.z   = 1'b0;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / bw;
            rem   = a % bw;
            e.r   = rem[7:0];
            e.z   = (e.q == 16'd0);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drives a one-cycle start. On return the current time is just after the
    // accepting edge.
    task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit expect_result);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (expect_result) sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits up to 40 edges for done. Returns the number of edges waited and
    // the number of sampled cycles in which busy was high.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, zero_flag, div_by_zero} !== 28'd0) begin
            errors++;
            $display("[TB] FAIL reset_during: got %h expected 0",
                     {busy, done, quotient, remainder, zero_flag, div_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, zero_flag, div_by_zero} !== 28'd0) begin
            errors++;
            $display("[TB] FAIL reset_after: got %h expected 0",
                     {busy, done, quotient, remainder, zero_flag, div_by_zero});
        end
    endtask

    task automatic test_basic();
        int   cyc;
        int   bcnt;
        exp_t e;
        issue(16'd1000, 8'd7, 1'b1);
        wait_done(cyc, bcnt);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 16", cyc);
        end
        checks++;
        if (bcnt !== 16) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d expected 16", bcnt);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e) begin
            errors++;
            $display("[TB] FAIL basic_result: got %h expected %h",
                     {quotient, remainder, zero_flag, div_by_zero}, e);
        end
        checks++;
        if (quotient !== 16'h008E || remainder !== 8'd6) begin
            errors++;
            $display("[TB] FAIL basic_1000_div_7: got q=%h r=%h expected q=008e r=06",
                     quotient, remainder);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_max();
        int   cyc;
        int   bcnt;
        exp_t e;
        issue(16'hFFFF, 8'hFF, 1'b1);
        wait_done(cyc, bcnt);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e || cyc !== 16) begin
            errors++;
            $display("[TB] FAIL max_ffff_div_ff: got %h after %0d edges expected %h after 16",
                     {quotient, remainder, zero_flag, div_by_zero}, cyc, e);
        end
        @(posedge clk);
        #1;
        issue(16'hFFFF, 8'h01, 1'b1);
        wait_done(cyc, bcnt);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e || cyc !== 16) begin
            errors++;
            $display("[TB] FAIL max_ffff_div_01: got %h after %0d edges expected %h after 16",
                     {quotient, remainder, zero_flag, div_by_zero}, cyc, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_quotient();
        int   cyc;
        int   bcnt;
        exp_t e;
        issue(16'd5, 8'd9, 1'b1);
        wait_done(cyc, bcnt);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e || cyc !== 16) begin
            errors++;
            $display("[TB] FAIL zeroq_result: got %h after %0d edges expected %h after 16",
                     {quotient, remainder, zero_flag, div_by_zero}, cyc, e);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({done, busy, quotient, remainder, zero_flag, div_by_zero} !==
                {1'b0, 1'b0, 16'd0, 8'd5, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL zeroq_hold cycle %0d: got %h expected %h", i,
                         {done, busy, quotient, remainder, zero_flag, div_by_zero},
                         {1'b0, 1'b0, 16'd0, 8'd5, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_div_by_zero();
        int   cyc;
        int   bcnt;
        exp_t e;
        issue(16'h1234, 8'd0, 1'b1);
        wait_done(cyc, bcnt);
        checks++;
        if (cyc !== 0 || bcnt !== 0) begin
            errors++;
            $display("[TB] FAIL dbz_timing: got latency=%0d busy=%0d expected 0 and 0", cyc, bcnt);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e) begin
            errors++;
            $display("[TB] FAIL dbz_result: got %h expected %h",
                     {quotient, remainder, zero_flag, div_by_zero}, e);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 8'h34, 1'b1}) begin
            errors++;
            $display("[TB] FAIL dbz_1234: got q=%h r=%h dbz=%b expected q=ffff r=34 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_after: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   bcnt;
        int   early;
        exp_t e;
        early = 0;
        issue(16'd100, 8'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            start    = 1'($urandom_range(0, 1));
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            #1;
            if (done) early++;
        end
        start = 1'b0;
        checks++;
        if (early !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_no_early_done: got %0d done cycles expected 0", early);
        end
        wait_done(cyc, bcnt);
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("[TB] FAIL b2b_first_latency: got %0d remaining edges expected 6", cyc);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e) begin
            errors++;
            $display("[TB] FAIL b2b_first_result: got %h expected %h",
                     {quotient, remainder, zero_flag, div_by_zero}, e);
        end
        // Start again in the done cycle.
        issue(16'd50, 8'd5, 1'b1);
        checks++;
        if (busy !== 1'b1 || quotient !== 16'd33 || remainder !== 8'd1) begin
            errors++;
            $display("[TB] FAIL b2b_hold_during_run: got busy=%b q=%h r=%h expected 1 0021 01",
                     busy, quotient, remainder);
        end
        wait_done(cyc, bcnt);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e || cyc !== 16) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %h after %0d edges expected %h after 16",
                     {quotient, remainder, zero_flag, div_by_zero}, cyc, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int   cyc;
        int   bcnt;
        int   dones;
        exp_t e;
        dones = 0;
        issue(16'h8000, 8'h03, 1'b0);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, zero_flag, div_by_zero} !== 28'd0) begin
            errors++;
            $display("[TB] FAIL abort_async_clear: got %h expected 0",
                     {busy, done, quotient, remainder, zero_flag, div_by_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", dones);
        end
        issue(16'd9, 8'd2, 1'b1);
        wait_done(cyc, bcnt);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if ({quotient, remainder, zero_flag, div_by_zero} !== e || cyc !== 16) begin
            errors++;
            $display("[TB] FAIL abort_next_div: got %h after %0d edges expected %h after 16",
                     {quotient, remainder, zero_flag, div_by_zero}, cyc, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int          cyc;
        int          bcnt;
        exp_t        e;
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = (i == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            issue(a, b, 1'b1);
            wait_done(cyc, bcnt);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            checks++;
            if ({quotient, remainder, zero_flag, div_by_zero} !== e ||
                cyc !== ((b == 8'd0) ? 0 : 16)) begin
                errors++;
                $display("[TB] FAIL random %h/%h: got %h after %0d edges expected %h",
                         a, b, {quotient, remainder, zero_flag, div_by_zero}, cyc, e);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_quotient();
        test_div_by_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
